// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Tracks up to ROB_SIZE-1 in-flight instructions (tags 1..ROB_SIZE-1; tag 0
//   means "no dependency") and retires them in program order. Results arrive
//   over two CDB ports (ALU, LSB). Retirement drives registered commit pulses.
//   A mispredicted branch or JALR raises a one-cycle flush that empties the
//   buffer.
//
// Ports
//   clk_in, rst_in (sync, active-high), rdy_in (global hold when low)
//   in_assign_enable/in_type/in_rd/in_pc/in_predict : issue from decode
//   out_tail, out_full                               : tag the next issue gets / no room
//   in_rs/rt_reorder -> out_rs/rt_ready, out_rs/rt_value : combinational operand lookup
//   in_alu_*, in_lsb_*                               : CDB result writes
//   out_commit_*                                     : registered retirement pulses
//   out_flush, out_flush_pc                          : registered redirect pulse
//
// Operator codes (in_type): 1 ADD, 2 JAL, 3 JALR, 4..9 BEQ/BNE/BLT/BGE/BLTU/BGEU,
//   10 SB, 11 SH, 12 SW, 13 LW; other codes are plain register writers.
//
// Build option: define ROB_BYPASS_EN to forward same-cycle CDB writes to the
//   operand lookup (ALU wins when both ports match the tag).
module reorder_buffer #(
  parameter int ROB_SIZE       = 16,
  parameter int OPERATOR_WIDTH = 6
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      in_assign_enable,
  input  logic [OPERATOR_WIDTH-1:0] in_type,
  input  logic [4:0]                in_rd,
  input  logic [31:0]               in_pc,
  input  logic                      in_predict,
  output logic [3:0]                out_tail,
  output logic                      out_full,
  input  logic [3:0]                in_rs_reorder,
  input  logic [3:0]                in_rt_reorder,
  output logic                      out_rs_ready,
  output logic                      out_rt_ready,
  output logic [31:0]               out_rs_value,
  output logic [31:0]               out_rt_value,
  input  logic                      in_alu_enable,
  input  logic [3:0]                in_alu_reorder,
  input  logic [31:0]               in_alu_value,
  input  logic                      in_alu_jump,
  input  logic [31:0]               in_alu_target,
  input  logic                      in_lsb_enable,
  input  logic [3:0]                in_lsb_reorder,
  input  logic [31:0]               in_lsb_value,
  output logic                      out_commit_reg_enable,
  output logic [4:0]                out_commit_rd,
  output logic [31:0]               out_commit_value,
  output logic [3:0]                out_commit_reorder,
  output logic                      out_commit_store,
  output logic                      out_flush,
  output logic [31:0]               out_flush_pc
);

  localparam logic [3:0] LAST_TAG   = 4'(ROB_SIZE - 1);
  localparam logic [4:0] FULL_COUNT = 5'(ROB_SIZE - 1);

  localparam logic [OPERATOR_WIDTH-1:0] OP_JAL  = OPERATOR_WIDTH'(2);
  localparam logic [OPERATOR_WIDTH-1:0] OP_JALR = OPERATOR_WIDTH'(3);
  localparam logic [OPERATOR_WIDTH-1:0] OP_BEQ  = OPERATOR_WIDTH'(4);
  localparam logic [OPERATOR_WIDTH-1:0] OP_BGEU = OPERATOR_WIDTH'(9);
  localparam logic [OPERATOR_WIDTH-1:0] OP_SB   = OPERATOR_WIDTH'(10);
  localparam logic [OPERATOR_WIDTH-1:0] OP_SH   = OPERATOR_WIDTH'(11);
  localparam logic [OPERATOR_WIDTH-1:0] OP_SW   = OPERATOR_WIDTH'(12);

  logic [ROB_SIZE-1:0]       busy_q, ready_q, predict_q, jump_q;
  logic [OPERATOR_WIDTH-1:0] type_q   [ROB_SIZE];
  logic [4:0]                rd_q     [ROB_SIZE];
  logic [31:0]               pc_q     [ROB_SIZE];
  logic [31:0]               value_q  [ROB_SIZE];
  logic [31:0]               target_q [ROB_SIZE];
  logic [3:0]                head_q, tail_q;
  logic [4:0]                count_q;

  logic                      do_issue, do_commit, do_flush, alu_wr, lsb_wr;
  logic [OPERATOR_WIDTH-1:0] head_type;

  function automatic logic is_store(input logic [OPERATOR_WIDTH-1:0] t);
    return (t == OP_SB) || (t == OP_SH) || (t == OP_SW);
  endfunction

  function automatic logic is_branch(input logic [OPERATOR_WIDTH-1:0] t);
    return (t >= OP_BEQ) && (t <= OP_BGEU);
  endfunction

  // Tag 0 is reserved, so pointers skip it on wrap.
  function automatic logic [3:0] next_tag(input logic [3:0] t);
    return (t == LAST_TAG) ? 4'd1 : t + 4'd1;
  endfunction

  assign out_tail = tail_q;
  assign out_full = (count_q == FULL_COUNT);

  always_comb begin
    head_type = type_q[head_q];
    do_issue  = rdy_in && in_assign_enable && !out_full;
    do_commit = rdy_in && busy_q[head_q] && ready_q[head_q];
    do_flush  = do_commit && (is_branch(head_type) || head_type == OP_JALR) &&
                (jump_q[head_q] != predict_q[head_q]);
    alu_wr    = rdy_in && in_alu_enable && (in_alu_reorder != 4'd0) && busy_q[in_alu_reorder];
    lsb_wr    = rdy_in && in_lsb_enable && (in_lsb_reorder != 4'd0) && busy_q[in_lsb_reorder];
  end

  function automatic logic [32:0] lookup(input logic [3:0] tag);
    logic [32:0] r;
    r = {ready_q[tag], value_q[tag]};
    if (tag == 4'd0) r = {1'b1, 32'd0};
`ifdef ROB_BYPASS_EN
    else if (alu_wr && in_alu_reorder == tag) r = {1'b1, in_alu_value};
    else if (lsb_wr && in_lsb_reorder == tag) r = {1'b1, in_lsb_value};
`endif
    return r;
  endfunction

  always_comb begin
    {out_rs_ready, out_rs_value} = lookup(in_rs_reorder);
    {out_rt_ready, out_rt_value} = lookup(in_rt_reorder);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q  <= '0;
      ready_q <= '0;
      jump_q  <= '0;
      for (int i = 0; i < ROB_SIZE; i++) value_q[i] <= '0;
      head_q  <= 4'd1;
      tail_q  <= 4'd1;
      count_q <= '0;
      out_commit_reg_enable <= 1'b0;
      out_commit_rd         <= '0;
      out_commit_value      <= '0;
      out_commit_reorder    <= '0;
      out_commit_store      <= 1'b0;
      out_flush             <= 1'b0;
      out_flush_pc          <= '0;
    end else begin
      // Pulses drop every cycle, including hold cycles, so a retirement is
      // never reported twice.
      out_commit_reg_enable <= 1'b0;
      out_commit_rd         <= '0;
      out_commit_value      <= '0;
      out_commit_reorder    <= '0;
      out_commit_store      <= 1'b0;
      out_flush             <= 1'b0;
      out_flush_pc          <= '0;
      if (do_flush) begin
        out_flush    <= 1'b1;
        out_flush_pc <= jump_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
        if ((head_type == OP_JAL || head_type == OP_JALR) && rd_q[head_q] != 5'd0) begin
          out_commit_reg_enable <= 1'b1;
          out_commit_rd         <= rd_q[head_q];
          out_commit_value      <= value_q[head_q];
          out_commit_reorder    <= head_q;
        end
        busy_q  <= '0;
        ready_q <= '0;
        head_q  <= 4'd1;
        tail_q  <= 4'd1;
        count_q <= '0;
      end else if (rdy_in) begin
        if (do_issue) begin
          busy_q[tail_q]    <= 1'b1;
          ready_q[tail_q]   <= is_store(in_type);
          type_q[tail_q]    <= in_type;
          rd_q[tail_q]      <= in_rd;
          pc_q[tail_q]      <= in_pc;
          predict_q[tail_q] <= in_predict;
          value_q[tail_q]   <= '0;
          jump_q[tail_q]    <= 1'b0;
          target_q[tail_q]  <= '0;
          tail_q            <= next_tag(tail_q);
        end
        if (alu_wr) begin
          ready_q[in_alu_reorder]  <= 1'b1;
          value_q[in_alu_reorder]  <= in_alu_value;
          jump_q[in_alu_reorder]   <= in_alu_jump;
          target_q[in_alu_reorder] <= in_alu_target;
        end
        if (lsb_wr) begin
          ready_q[in_lsb_reorder] <= 1'b1;
          value_q[in_lsb_reorder] <= in_lsb_value;
        end
        // Placed after the CDB writes so freeing the head always wins.
        if (do_commit) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= next_tag(head_q);
          if (is_store(head_type)) begin
            out_commit_store   <= 1'b1;
            out_commit_reorder <= head_q;
          end else if (!is_branch(head_type) && rd_q[head_q] != 5'd0) begin
            out_commit_reg_enable <= 1'b1;
            out_commit_rd         <= rd_q[head_q];
            out_commit_value      <= value_q[head_q];
            out_commit_reorder    <= head_q;
          end
        end
        if (do_issue && !do_commit)      count_q <= count_q + 5'd1;
        else if (!do_issue && do_commit) count_q <= count_q - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios followed by random traffic,
// checked against a queue-based model of in-order retirement.
module tb_reorder_buffer;

  localparam logic [5:0] T_ADD = 6'd1, T_JAL = 6'd2, T_JALR = 6'd3, T_BEQ = 6'd4,
                         T_BNE = 6'd5, T_BLT = 6'd6, T_BGEU = 6'd9, T_SB = 6'd10,
                         T_SH = 6'd11, T_SW = 6'd12, T_LW = 6'd13;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        in_assign_enable, in_predict;
  logic [5:0]  in_type;
  logic [4:0]  in_rd;
  logic [31:0] in_pc;
  logic [3:0]  out_tail;
  logic        out_full;
  logic [3:0]  in_rs_reorder, in_rt_reorder;
  logic        out_rs_ready, out_rt_ready;
  logic [31:0] out_rs_value, out_rt_value;
  logic        in_alu_enable, in_alu_jump;
  logic [3:0]  in_alu_reorder;
  logic [31:0] in_alu_value, in_alu_target;
  logic        in_lsb_enable;
  logic [3:0]  in_lsb_reorder;
  logic [31:0] in_lsb_value;
  logic        out_commit_reg_enable, out_commit_store, out_flush;
  logic [4:0]  out_commit_rd;
  logic [31:0] out_commit_value, out_flush_pc;
  logic [3:0]  out_commit_reorder;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.ROB_SIZE(16), .OPERATOR_WIDTH(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .in_assign_enable(in_assign_enable), .in_type(in_type), .in_rd(in_rd),
    .in_pc(in_pc), .in_predict(in_predict),
    .out_tail(out_tail), .out_full(out_full),
    .in_rs_reorder(in_rs_reorder), .in_rt_reorder(in_rt_reorder),
    .out_rs_ready(out_rs_ready), .out_rt_ready(out_rt_ready),
    .out_rs_value(out_rs_value), .out_rt_value(out_rt_value),
    .in_alu_enable(in_alu_enable), .in_alu_reorder(in_alu_reorder),
    .in_alu_value(in_alu_value), .in_alu_jump(in_alu_jump), .in_alu_target(in_alu_target),
    .in_lsb_enable(in_lsb_enable), .in_lsb_reorder(in_lsb_reorder), .in_lsb_value(in_lsb_value),
    .out_commit_reg_enable(out_commit_reg_enable), .out_commit_rd(out_commit_rd),
    .out_commit_value(out_commit_value), .out_commit_reorder(out_commit_reorder),
    .out_commit_store(out_commit_store), .out_flush(out_flush), .out_flush_pc(out_flush_pc)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [5:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        predict;
    logic        ready;
    logic [31:0] value;
    logic        jump;
    logic [31:0] target;
  } ent_t;

  typedef struct {
    logic        reg_en;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [3:0]  reorder;
    logic        store;
    logic        flush;
    logic [31:0] flush_pc;
  } ev_t;

  ent_t       rob[$];
  ev_t        exp_q[$];
  logic [3:0] m_tail;
  logic       mon_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [5:0] type_pool [14] = '{T_ADD, T_ADD, T_ADD, T_ADD, T_LW, T_LW, T_SW, T_SB,
                                 T_SH, T_BEQ, T_BNE, T_BLT, T_JAL, T_JALR};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_store(input logic [5:0] t);
    return t == T_SB || t == T_SH || t == T_SW;
  endfunction

  function automatic logic is_branch(input logic [5:0] t);
    return t >= T_BEQ && t <= T_BGEU;
  endfunction

  function automatic logic in_flight(input logic [3:0] tag);
    foreach (rob[i]) if (rob[i].tag == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ev_t new_ev();
    ev_t e;
    e.reg_en = 0; e.rd = 0; e.value = 0; e.reorder = 0;
    e.store = 0; e.flush = 0; e.flush_pc = 0;
    return e;
  endfunction

  function automatic void exp_lookup(input logic [3:0] tag, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = 32'd0;
    if (tag == 4'd0) begin
      r = 1'b1;
      return;
    end
    foreach (rob[i]) if (rob[i].tag == tag) begin
      r = rob[i].ready;
      v = rob[i].value;
    end
`ifdef ROB_BYPASS_EN
    if (rdy_in && in_alu_enable && in_alu_reorder == tag && in_flight(tag)) begin
      r = 1'b1; v = in_alu_value;
    end else if (rdy_in && in_lsb_enable && in_lsb_reorder == tag && in_flight(tag)) begin
      r = 1'b1; v = in_lsb_value;
    end
`endif
  endfunction

  // Advances the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    ent_t h, e;
    ev_t  ev;
    logic commit, full;
    if (rst_in) begin
      rob.delete();
      m_tail = 4'd1;
      return;
    end
    if (!rdy_in) return;
    full   = (rob.size() == 15);
    commit = (rob.size() > 0) && rob[0].ready;
    if (commit) begin
      h = rob[0];
      if ((is_branch(h.typ) || h.typ == T_JALR) && h.jump != h.predict) begin
        ev = new_ev();
        ev.flush    = 1'b1;
        ev.flush_pc = h.jump ? h.target : h.pc + 32'd4;
        if ((h.typ == T_JAL || h.typ == T_JALR) && h.rd != 0) begin
          ev.reg_en = 1'b1; ev.rd = h.rd; ev.value = h.value; ev.reorder = h.tag;
        end
        exp_q.push_back(ev);
        rob.delete();
        m_tail = 4'd1;
        return;
      end
    end
    for (int i = 0; i < rob.size(); i++) begin
      e = rob[i];
      if (in_alu_enable && e.tag == in_alu_reorder) begin
        e.ready = 1'b1; e.value = in_alu_value; e.jump = in_alu_jump; e.target = in_alu_target;
      end
      if (in_lsb_enable && e.tag == in_lsb_reorder) begin
        e.ready = 1'b1; e.value = in_lsb_value;
      end
      rob[i] = e;
    end
    if (in_assign_enable && !full) begin
      e.tag = m_tail; e.typ = in_type; e.rd = in_rd; e.pc = in_pc; e.predict = in_predict;
      e.ready = is_store(in_type); e.value = 0; e.jump = 0; e.target = 0;
      rob.push_back(e);
      m_tail = (m_tail == 4'd15) ? 4'd1 : m_tail + 4'd1;
    end
    if (commit) begin
      void'(rob.pop_front());
      ev = new_ev();
      if (is_store(h.typ)) begin
        ev.store = 1'b1; ev.reorder = h.tag;
        exp_q.push_back(ev);
      end else if (!is_branch(h.typ) && h.rd != 0) begin
        ev.reg_en = 1'b1; ev.rd = h.rd; ev.value = h.value; ev.reorder = h.tag;
        exp_q.push_back(ev);
      end
    end
  endtask

  // Inputs are applied by the caller just after a rising edge.
  task automatic step();
    logic        er;
    logic [31:0] ev;
    #1;
    exp_lookup(in_rs_reorder, er, ev);
    chk("rs_ready", 32'(out_rs_ready), 32'(er));
    if (er) chk("rs_value", out_rs_value, ev);
    exp_lookup(in_rt_reorder, er, ev);
    chk("rt_ready", 32'(out_rt_ready), 32'(er));
    if (er) chk("rt_value", out_rt_value, ev);
    chk("tail", 32'(out_tail), 32'(m_tail));
    chk("full", 32'(out_full), 32'(rob.size() == 15));
    model_edge();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rst_in = 0; rdy_in = 1; in_assign_enable = 0; in_type = T_ADD; in_rd = 0; in_pc = 0;
    in_predict = 0; in_rs_reorder = 0; in_rt_reorder = 0;
    in_alu_enable = 0; in_alu_reorder = 0; in_alu_value = 0; in_alu_jump = 0; in_alu_target = 0;
    in_lsb_enable = 0; in_lsb_reorder = 0; in_lsb_value = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1;
    step();
    rst_in = 0;
  endtask

  task automatic issue(input logic [5:0] t, input logic [4:0] rd, input logic [31:0] pc,
                       input logic pred);
    in_assign_enable = 1; in_type = t; in_rd = rd; in_pc = pc; in_predict = pred;
    step();
    in_assign_enable = 0;
  endtask

  task automatic alu_write(input logic [3:0] tag, input logic [31:0] v, input logic j,
                           input logic [31:0] tgt);
    in_alu_enable = 1; in_alu_reorder = tag; in_alu_value = v; in_alu_jump = j; in_alu_target = tgt;
    step();
    in_alu_enable = 0;
  endtask

  task automatic rand_inputs();
    rst_in           = ($urandom_range(0, 199) == 0);
    rdy_in           = ($urandom_range(0, 9) != 0);
    in_assign_enable = ($urandom_range(0, 2) != 0);
    in_type          = type_pool[$urandom_range(0, 13)];
    in_rd            = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    in_pc            = $urandom & 32'h0000_fffc;
    in_predict       = 1'($urandom_range(0, 1));
    in_alu_enable    = ($urandom_range(0, 1) != 0);
    if (rob.size() > 0 && $urandom_range(0, 3) != 0)
      in_alu_reorder = rob[$urandom_range(0, rob.size() - 1)].tag;
    else
      in_alu_reorder = 4'($urandom_range(0, 15));
    in_alu_value     = $urandom;
    in_alu_jump      = 1'($urandom_range(0, 1));
    in_alu_target    = $urandom & 32'h0000_fffc;
    in_lsb_enable    = ($urandom_range(0, 2) == 0);
    if (rob.size() > 0 && $urandom_range(0, 1) != 0)
      in_lsb_reorder = rob[$urandom_range(0, rob.size() - 1)].tag;
    else
      in_lsb_reorder = 4'($urandom_range(0, 15));
    in_lsb_value     = $urandom;
    if (in_alu_enable && in_lsb_enable && in_alu_reorder == in_lsb_reorder) in_lsb_enable = 0;
    in_rs_reorder    = ($urandom_range(0, 3) == 0) ? in_alu_reorder : 4'($urandom_range(0, 15));
    in_rt_reorder    = 4'($urandom_range(0, 15));
  endtask

  // Scoreboard monitor: every pulse the DUT presents is matched to the next
  // expected retirement event; quiet cycles must leave all outputs at zero.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk_in);
      if (mon_en) begin
        if (out_commit_reg_enable || out_commit_store || out_flush) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: reg_en=%0b store=%0b flush=%0b with nothing expected at %0t",
                     out_commit_reg_enable, out_commit_store, out_flush, $time);
          end else begin
            e = exp_q.pop_front();
            chk("commit_reg_enable", 32'(out_commit_reg_enable), 32'(e.reg_en));
            chk("commit_rd", 32'(out_commit_rd), 32'(e.rd));
            chk("commit_value", out_commit_value, e.value);
            chk("commit_reorder", 32'(out_commit_reorder), 32'(e.reorder));
            chk("commit_store", 32'(out_commit_store), 32'(e.store));
            chk("flush", 32'(out_flush), 32'(e.flush));
            chk("flush_pc", out_flush_pc, e.flush_pc);
          end
        end else begin
          chk("idle_outputs", out_commit_value | out_flush_pc | 32'(out_commit_rd) |
              32'(out_commit_reorder), 32'd0);
        end
      end
    end
  end

  initial begin
    idle_inputs();
    rst_in = 1;
    repeat (2) @(posedge clk_in);
    #1;
    rob.delete();
    m_tail = 4'd1;
    mon_en = 1'b1;

    // Reset state, then ADD rd=5 written by the ALU retires with 0x2A.
    do_reset();
    chk("reset_tail", 32'(out_tail), 32'd1);
    chk("reset_full", 32'(out_full), 32'd0);
    chk("reset_commit", 32'({out_commit_reg_enable, out_commit_store, out_flush}), 32'd0);
    issue(T_ADD, 5'd5, 32'h0, 1'b0);
    alu_write(4'd1, 32'h2A, 1'b0, 32'h0);
    step();
    chk("add_reg_enable", 32'(out_commit_reg_enable), 32'd1);
    chk("add_rd", 32'(out_commit_rd), 32'd5);
    chk("add_value", out_commit_value, 32'h2A);
    chk("add_reorder", 32'(out_commit_reorder), 32'd1);

    // Fill all 15 slots; the tail wraps to 1 and a further assign is dropped.
    do_reset();
    for (int i = 0; i < 15; i++) issue(T_ADD, 5'd1, 32'(i * 4), 1'b0);
    chk("fill_full", 32'(out_full), 32'd1);
    chk("fill_tail", 32'(out_tail), 32'd1);
    in_assign_enable = 1;
    in_alu_enable = 1; in_alu_reorder = 4'd3; in_alu_value = 32'h7; in_rs_reorder = 4'd3;
    #1;
`ifdef ROB_BYPASS_EN
    chk("bypass_ready", 32'(out_rs_ready), 32'd1);
    chk("bypass_value", out_rs_value, 32'h7);
`else
    chk("nobypass_ready", 32'(out_rs_ready), 32'd0);
`endif
    step();
    idle_inputs();
    chk("full_assign_tail", 32'(out_tail), 32'd1);
    chk("full_assign_full", 32'(out_full), 32'd1);
    in_rs_reorder = 4'd3;
    #1;
    chk("registered_ready", 32'(out_rs_ready), 32'd1);
    chk("registered_value", out_rs_value, 32'h7);
    in_rs_reorder = 4'd0;
    // Head becomes ready, but reset on the following edge retires nothing.
    alu_write(4'd1, 32'h9, 1'b0, 32'h0);
    rst_in = 1;
    step();
    rst_in = 0;
    chk("midreset_commit", 32'(out_commit_reg_enable), 32'd0);
    chk("midreset_tail", 32'(out_tail), 32'd1);
    chk("midreset_full", 32'(out_full), 32'd0);

    // Mispredicted BEQ flushes; a same-cycle issue is discarded.
    issue(T_BEQ, 5'd0, 32'h100, 1'b0);
    issue(T_ADD, 5'd7, 32'h104, 1'b0);
    alu_write(4'd1, 32'h0, 1'b1, 32'h80);
    in_assign_enable = 1; in_type = T_ADD; in_rd = 5'd2;
    step();
    in_assign_enable = 0;
    chk("flush_pulse", 32'(out_flush), 32'd1);
    chk("flush_pc_taken", out_flush_pc, 32'h80);
    chk("flush_tail", 32'(out_tail), 32'd1);
    chk("flush_full", 32'(out_full), 32'd0);
    step();
    chk("flush_one_cycle", 32'(out_flush), 32'd0);

    // Store behind an unready ADD waits, then retires the cycle after it.
    do_reset();
    issue(T_ADD, 5'd3, 32'h0, 1'b0);
    issue(T_SW, 5'd0, 32'h4, 1'b0);
    repeat (3) step();
    chk("store_blocked", 32'(out_commit_store), 32'd0);
    alu_write(4'd1, 32'h5, 1'b0, 32'h0);
    step();
    chk("head_commit_rd", 32'(out_commit_rd), 32'd3);
    step();
    chk("store_pulse", 32'(out_commit_store), 32'd1);
    chk("store_reorder", 32'(out_commit_reorder), 32'd2);

    // rdy_in low: the CDB write and any retirement are held off.
    do_reset();
    issue(T_ADD, 5'd4, 32'h0, 1'b0);
    rdy_in = 0;
    alu_write(4'd1, 32'h55, 1'b0, 32'h0);
    in_rs_reorder = 4'd1;
    step();
    chk("hold_no_commit", 32'(out_commit_reg_enable), 32'd0);
    rdy_in = 1;
    #1;
    chk("hold_not_ready", 32'(out_rs_ready), 32'd0);
    step();
    chk("hold_still_no_commit", 32'(out_commit_reg_enable), 32'd0);
    alu_write(4'd1, 32'h56, 1'b0, 32'h0);
    step();
    chk("release_value", out_commit_value, 32'h56);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end
    idle_inputs();
    repeat (3) step();
    chk("pending_events", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
